// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for the pipelined adder and its segments.
//   add_op_e  : per-transaction operation (add / subtract)
//   seg_width : bits handled by each pipeline stage (ceil(width/stages))
//   sat_max / sat_min : clamp bounds, returned in the low 'width' bits of a
//                       64-bit word so callers can slice them to size
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  // Carry-chain bits per stage; later stages may end up partially or fully empty
  function automatic int seg_width(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Largest representable value: 2^(w-1)-1 signed, 2^w-1 unsigned.
  // For width 64 the unsigned shift wraps to 0 and the subtraction gives all ones.
  function automatic logic [63:0] sat_max(int width, bit isSigned);
    if (isSigned) begin
      return (64'd1 << (width - 1)) - 64'd1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  // Smallest representable value: -2^(w-1) signed (only the sign bit set in
  // the low w bits), 0 unsigned
  function automatic logic [63:0] sat_min(int width, bit isSigned);
    if (isSigned) begin
      return 64'd1 << (width - 1);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
// Combinational ripple-carry adder of SEG_W bits built from full_adder cells.
// One instance covers the slice of the operands owned by a single pipeline
// stage.
//   a_i, b_i  : operand slices (b already inverted for subtraction)
//   carry_i   : carry from the previous stage's register
//   sum_o     : slice sum
//   carry_o   : carry into the next stage
// -----------------------------------------------------------------------------
module adder_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             carry_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             carry_o
);

  // Each bit keeps its own carry nets so the ripple is a chain of distinct
  // signals rather than one vector feeding back into itself
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    logic cIn;
    logic cOut;

    if (i == 0) begin : g_first
      assign cIn = carry_i;
    end else begin : g_next
      assign cIn = g_bit[i-1].cOut;
    end

    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .carry_i(cIn),
      .sum_o  (sum_o[i]),
      .carry_o(cOut)
    );
  end

  assign carry_o = g_bit[SEG_W-1].cOut;

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, the building block of every carry-chain segment.
//   a_i, b_i  : operand bits
//   carry_i   : carry in
//   sum_o     : sum bit
//   carry_o   : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  // Plain gate-level sum and majority carry
  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder/subtractor whose carry chain is cut into STAGES registered
// segments, with valid/ready flow control, a saturated result, an overflow
// flag and a tag that travels with each operation.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operation handshake
//   in_opA, in_opB       : operands
//   in_sub               : 0 = A+B, 1 = A-B
//   in_tag               : sideband returned with the result
//   out_valid / out_ready: result handshake
//   out_sum              : exact WIDTH+1-bit result (carry/borrow or sign)
//   out_sat              : result clamped to WIDTH bits
//   out_ovf              : set when out_sat differs from out_sum
//   out_tag              : tag of the presented result
// -----------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH-1:0] out_sat,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  localparam logic [63:0]      SAT_MAX_FULL = sat_max(WIDTH, SIGNED != 0);
  localparam logic [63:0]      SAT_MIN_FULL = sat_min(WIDTH, SIGNED != 0);
  localparam logic [WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

  // Per-stage registers: full operands ride along so later stages can reach
  // their slice, and the partial sum accumulates one slice per stage
  logic [STAGES-1:0] validQ;
  logic [WIDTH-1:0]  aQ     [STAGES];
  logic [WIDTH-1:0]  bQ     [STAGES];
  logic [WIDTH-1:0]  sumQ   [STAGES];
  logic              carryQ [STAGES];
  add_op_e           opQ    [STAGES];
  logic [TAG_W-1:0]  tagQ   [STAGES];

  logic [WIDTH-1:0]  aD     [STAGES];
  logic [WIDTH-1:0]  bD     [STAGES];
  logic [WIDTH-1:0]  sumD   [STAGES];
  logic              carryD [STAGES];
  add_op_e           opD    [STAGES];
  logic [TAG_W-1:0]  tagD   [STAGES];

  logic [STAGES-1:0] loadStage;
  logic [STAGES-1:0] validSrc;

  // Stage datapath: pick the source (ports for stage 0, previous stage
  // otherwise), add this stage's slice and pass every other bit through
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
    localparam int SW = (HI > LO) ? HI - LO : 0;

    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] srcSum;
    logic             srcCarry;
    add_op_e          srcOp;
    logic [TAG_W-1:0] srcTag;

    if (k == 0) begin : g_src_port
      // Subtraction is A + ~B + 1: invert B once here, carry-in supplies the +1
      assign srcA     = in_opA;
      assign srcB     = in_sub ? ~in_opB : in_opB;
      assign srcSum   = '0;
      assign srcCarry = in_sub;
      assign srcOp    = in_sub ? OP_SUB : OP_ADD;
      assign srcTag   = in_tag;
    end else begin : g_src_stage
      assign srcA     = aQ[k-1];
      assign srcB     = bQ[k-1];
      assign srcSum   = sumQ[k-1];
      assign srcCarry = carryQ[k-1];
      assign srcOp    = opQ[k-1];
      assign srcTag   = tagQ[k-1];
    end

    assign aD[k]   = srcA;
    assign bD[k]   = srcB;
    assign opD[k]  = srcOp;
    assign tagD[k] = srcTag;

    if (SW > 0) begin : g_seg
      logic [SW-1:0]    segSum;
      logic             segCarry;
      logic [WIDTH-1:0] merged;

      adder_segment #(.SEG_W(SW)) u_seg (
        .a_i    (srcA[LO +: SW]),
        .b_i    (srcB[LO +: SW]),
        .carry_i(srcCarry),
        .sum_o  (segSum),
        .carry_o(segCarry)
      );

      always_comb begin
        merged          = srcSum;
        merged[LO +: SW] = segSum;
      end

      assign sumD[k]   = merged;
      assign carryD[k] = segCarry;
    end else begin : g_empty
      // No bits left for this stage; it only adds a register delay
      assign sumD[k]   = srcSum;
      assign carryD[k] = srcCarry;
    end
  end

  // A stage may load when it is empty or its content moves on this cycle;
  // walking from the output back lets bubbles collapse in one cycle
  always_comb begin : p_load
    logic chain;
    chain     = out_ready;
    loadStage = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain        = !validQ[k] | chain;
      loadStage[k] = chain;
    end
  end

  // Valid bit each stage takes when it loads
  always_comb begin
    validSrc    = '0;
    validSrc[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      validSrc[k] = validQ[k-1];
    end
  end

  // Pipeline registers. Data only moves with a valid operation so the output
  // registers keep their last real result (or zero after reset) during bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      for (int k = 0; k < STAGES; k++) begin
        aQ[k]     <= '0;
        bQ[k]     <= '0;
        sumQ[k]   <= '0;
        carryQ[k] <= 1'b0;
        opQ[k]    <= OP_ADD;
        tagQ[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (loadStage[k]) begin
          validQ[k] <= validSrc[k];
          if (validSrc[k]) begin
            aQ[k]     <= aD[k];
            bQ[k]     <= bD[k];
            sumQ[k]   <= sumD[k];
            carryQ[k] <= carryD[k];
            opQ[k]    <= opD[k];
            tagQ[k]   <= tagD[k];
          end
        end
      end
    end
  end

  assign in_ready  = loadStage[0] & ~rst;
  assign out_valid = validQ[LAST];
  assign out_tag   = tagQ[LAST];

  // Result interpretation straight from the last-stage registers.
  // Signed: the extra top bit is the sign of the sign-extended sum, i.e. both
  // operand MSBs (B already inverted for sub) xor the final carry; overflow is
  // when it disagrees with bit WIDTH-1. Unsigned: top bit is carry for add and
  // borrow (inverted carry) for sub, and any set top bit means clamping.
  logic [WIDTH-1:0] lastSum;
  logic             exactTop;
  logic             ovf;
  logic [WIDTH-1:0] clamp;

  always_comb begin
    lastSum  = sumQ[LAST];
    exactTop = 1'b0;
    ovf      = 1'b0;
    clamp    = SAT_MAX;
    if (SIGNED != 0) begin
      exactTop = aQ[LAST][WIDTH-1] ^ bQ[LAST][WIDTH-1] ^ carryQ[LAST];
      ovf      = exactTop ^ lastSum[WIDTH-1];
      clamp    = exactTop ? SAT_MIN : SAT_MAX;
    end else begin
      exactTop = (opQ[LAST] == OP_SUB) ? ~carryQ[LAST] : carryQ[LAST];
      ovf      = exactTop;
      clamp    = (opQ[LAST] == OP_SUB) ? SAT_MIN : SAT_MAX;
    end
  end

  assign out_sum = {exactTop, lastSum};
  assign out_sat = ovf ? clamp : lastSum;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Three copies of the adder share one stimulus stream: 8-bit unsigned with two
// stages, 8-bit signed with two stages, and 8-bit unsigned with three stages.
// A vector table covers the arithmetic, then directed sequences cover
// streaming, backpressure and reset with operations in flight.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic [7:0] inOpA = '0;
  logic [7:0] inOpB = '0;
  logic       inSub = 1'b0;
  logic [3:0] inTag = '0;
  logic       outReady = 1'b1;

  logic       inReadyU, outValidU, outOvfU;
  logic [8:0] outSumU;
  logic [7:0] outSatU;
  logic [3:0] outTagU;

  logic       inReadyS, outValidS, outOvfS;
  logic [8:0] outSumS;
  logic [7:0] outSatS;
  logic [3:0] outTagS;

  logic       inReadyT, outValidT, outOvfT;
  logic [8:0] outSumT;
  logic [7:0] outSatT;
  logic [3:0] outTagT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [8:0] sumU;
    logic [7:0] satU;
    logic       ovfU;
    logic [8:0] sumS;
    logic [7:0] satS;
    logic       ovfS;
  } vec_t;

  vec_t vecs [10];

  pipelined_adder #(.WIDTH(8), .STAGES(2), .SIGNED(0), .TAG_W(4)) dutU (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyU),
    .in_opA(inOpA), .in_opB(inOpB), .in_sub(inSub), .in_tag(inTag),
    .out_valid(outValidU), .out_ready(outReady), .out_sum(outSumU),
    .out_sat(outSatU), .out_ovf(outOvfU), .out_tag(outTagU)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(2), .SIGNED(1), .TAG_W(4)) dutS (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyS),
    .in_opA(inOpA), .in_opB(inOpB), .in_sub(inSub), .in_tag(inTag),
    .out_valid(outValidS), .out_ready(outReady), .out_sum(outSumS),
    .out_sat(outSatS), .out_ovf(outOvfS), .out_tag(outTagS)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(3), .SIGNED(0), .TAG_W(4)) dutT (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyT),
    .in_opA(inOpA), .in_opB(inOpB), .in_sub(inSub), .in_tag(inTag),
    .out_valid(outValidT), .out_ready(outReady), .out_sum(outSumT),
    .out_sat(outSatT), .out_ovf(outOvfT), .out_tag(outTagT)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  // Drive one operation (or a bubble) onto the shared input bus
  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic sub, input logic [3:0] tag);
    inValid = valid;
    inOpA   = a;
    inOpB   = b;
    inSub   = sub;
    inTag   = tag;
  endtask

  // Compare one observed value with its expected value and keep the tallies
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Main sequence: reset, vector table, streaming, backpressure, reset mid-flight
  initial begin
    int seen;
    logic [3:0] expTag [3];

    //                a      b      sub   sumU    satU   ovfU  sumS    satS   ovfS
    vecs[0] = '{8'hC8, 8'h64, 1'b0, 9'h12C, 8'hFF, 1'b1, 9'h02C, 8'h2C, 1'b0};
    vecs[1] = '{8'h80, 8'h01, 1'b1, 9'h07F, 8'h7F, 1'b0, 9'h17F, 8'h80, 1'b1};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 9'h1FE, 8'h00, 1'b1, 9'h1FE, 8'hFE, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 9'h100, 8'hFF, 1'b1, 9'h000, 8'h00, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 9'h080, 8'h80, 1'b0, 9'h080, 8'h7F, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 9'h000, 8'h00, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 9'h046, 8'h46, 1'b0, 9'h046, 8'h46, 1'b0};
    vecs[7] = '{8'h10, 8'h20, 1'b1, 9'h1F0, 8'h00, 1'b1, 9'h1F0, 8'hF0, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 9'h100, 8'hFF, 1'b1, 9'h100, 8'h80, 1'b1};
    vecs[9] = '{8'h7F, 8'h80, 1'b1, 9'h1FF, 8'h00, 1'b1, 9'h0FF, 8'h7F, 1'b1};

    // Reset state
    #2;
    checkOutput("reset out_valid", outValidU, 0);
    checkOutput("reset in_ready", inReadyU, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", inReadyU, 1);
    checkOutput("post-reset out_valid", outValidU, 0);
    checkOutput("post-reset out_sum", outSumU, 0);
    checkOutput("post-reset out_sat", outSatU, 0);
    checkOutput("post-reset out_ovf", outOvfU, 0);
    checkOutput("post-reset out_tag", outTagU, 0);
    checkOutput("post-reset signed out_sum", outSumS, 0);

    // Vector table: one op at a time, checking exact latency of both depths
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 4'(i));
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      checkOutput($sformatf("v%0d U valid early", i), outValidU, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d U valid", i), outValidU, 1);
      checkOutput($sformatf("v%0d U sum", i), outSumU, vecs[i].sumU);
      checkOutput($sformatf("v%0d U sat", i), outSatU, vecs[i].satU);
      checkOutput($sformatf("v%0d U ovf", i), outOvfU, vecs[i].ovfU);
      checkOutput($sformatf("v%0d U tag", i), outTagU, 32'(i));
      checkOutput($sformatf("v%0d S valid", i), outValidS, 1);
      checkOutput($sformatf("v%0d S sum", i), outSumS, vecs[i].sumS);
      checkOutput($sformatf("v%0d S sat", i), outSatS, vecs[i].satS);
      checkOutput($sformatf("v%0d S ovf", i), outOvfS, vecs[i].ovfS);
      checkOutput($sformatf("v%0d S tag", i), outTagS, 32'(i));
      checkOutput($sformatf("v%0d T valid early", i), outValidT, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d U drained", i), outValidU, 0);
      checkOutput($sformatf("v%0d T valid", i), outValidT, 1);
      checkOutput($sformatf("v%0d T sum", i), outSumT, vecs[i].sumU);
      checkOutput($sformatf("v%0d T sat", i), outSatT, vecs[i].satU);
      checkOutput($sformatf("v%0d T ovf", i), outOvfT, vecs[i].ovfU);
      checkOutput($sformatf("v%0d T tag", i), outTagT, 32'(i));
    end
    @(negedge clk);

    // Four back-to-back ops: results on cycles 2..5 in tag order
    for (int c = 0; c < 7; c++) begin
      logic expV;
      @(negedge clk);
      expV = (c >= 2) && (c <= 5);
      checkOutput($sformatf("b2b valid c%0d", c), outValidU, 32'(expV));
      if (expV) begin
        checkOutput($sformatf("b2b tag c%0d", c), outTagU, 32'(c - 2));
        checkOutput($sformatf("b2b sum c%0d", c), outSumU, 32'(2 * (c - 2)));
      end
      if (c < 4) applyStimulus(1'b1, 8'(c), 8'(c), 1'b0, 4'(c));
      else       applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    end

    // Backpressure: consumer stalls while the producer keeps offering
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, 4'd8);
    @(negedge clk);
    checkOutput("bp in_ready one held", inReadyU, 1);
    applyStimulus(1'b1, 8'd2, 8'd2, 1'b0, 4'd9);
    @(negedge clk);
    checkOutput("bp in_ready full", inReadyU, 0);
    checkOutput("bp out_valid", outValidU, 1);
    checkOutput("bp tag held", outTagU, 8);
    checkOutput("bp sum held", outSumU, 2);
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b0, 4'd10);
    @(negedge clk);
    checkOutput("bp in_ready still full", inReadyU, 0);
    checkOutput("bp tag stable", outTagU, 8);
    checkOutput("bp sum stable", outSumU, 2);
    @(negedge clk);
    checkOutput("bp tag stable 2", outTagU, 8);
    outReady = 1'b1;
    #1;
    checkOutput("bp in_ready on release", inReadyU, 1);
    expTag[0] = 4'd8;
    expTag[1] = 4'd9;
    expTag[2] = 4'd10;
    seen = 0;
    if (outValidU) seen = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      if (outValidU) begin
        if (seen < 3) begin
          checkOutput($sformatf("bp order tag %0d", seen), outTagU, expTag[seen]);
          checkOutput($sformatf("bp order sum %0d", seen), outSumU, 32'(2 * (seen + 1)));
        end
        seen++;
      end
    end
    checkOutput("bp result count", seen, 3);

    // Reset with two operations in flight
    @(negedge clk);
    applyStimulus(1'b1, 8'h20, 8'h05, 1'b0, 4'd5);
    @(negedge clk);
    applyStimulus(1'b1, 8'h30, 8'h06, 1'b0, 4'd6);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    rst = 1'b1;
    #1;
    checkOutput("mid-reset out_valid", outValidU, 0);
    checkOutput("mid-reset in_ready", inReadyU, 0);
    checkOutput("mid-reset T out_valid", outValidT, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("after reset in_ready", inReadyU, 1);
      checkOutput($sformatf("no stale result c%0d", c), outValidU, 0);
    end
    checkOutput("after reset sum cleared", outSumU, 0);
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0, 4'd7);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("fresh op valid", outValidU, 1);
    checkOutput("fresh op sum", outSumU, 9'h033);
    checkOutput("fresh op tag", outTagU, 7);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the gate-level ripple adder. The WIDTH-bit carry chain is split into STAGES registered segments, and the block adds per-transaction add/subtract, signed/unsigned modes, a saturated result and an overflow flag. A valid/ready handshake with per-stage valid bits lets it sit between spike-accumulation producers and the membrane-potential update logic. A TAG_W sideband (channel/neuron ID) travels in lockstep with each operation.

Parameters:
WIDTH, 8, operand width in bits (>=2)
STAGES, 2, pipeline stages = carry-chain segments (1..WIDTH); latency in cycles
SIGNED, 0, 1 = two's-complement operands/results, 0 = unsigned
TAG_W, 4, sideband tag width (>=1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
in_opA  in  WIDTH  operand A
in_opB  in  WIDTH  operand B
in_sub  in  1  0 = A+B, 1 = A-B
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH+1  exact result (see arithmetic)
out_sat  out  WIDTH  result clamped to WIDTH bits
out_ovf  out  1  1 when out_sat != exact result
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: all stage valid bits 0 immediately (async); out_valid=0, in_ready=0 while rst high; data registers need no reset value, but out_sum/out_sat/out_ovf/out_tag read 0 after reset.
- SEG = ceil(WIDTH/STAGES). Stage k (0-based) adds operand bits [k*SEG, min((k+1)*SEG, WIDTH)-1] using the registered carry from stage k-1. Stage 0 carry-in = in_sub. Upper operand bits are delayed alongside. An empty segment (k*SEG >= WIDTH) passes through.
- Subtract: opB is bit-inverted at stage 0 input, carry-in = 1.
- Latency: exactly STAGES cycles from accept (in_valid&in_ready) to out_valid when unstalled. Throughput is one op per cycle.
- Handshake:
  - Stage k loads when !valid[k] or stage k+1 loads; the last stage "loads onward" when out_ready.
  - in_ready = stage-0 load condition (bubbles collapse).
  - out_valid = valid[last]. Outputs hold stable while out_valid & !out_ready.
  - No loss, duplication or reordering.
- Simultaneous accept and drain in a full pipeline: allowed; the pipeline advances in place.
- Arithmetic, unsigned:
  - add: out_sum = {carry, bits}.
  - sub: out_sum[WIDTH] = borrow (1 iff A<B), low bits = (A-B) mod 2^WIDTH.
  - out_sat: add clamps to 2^WIDTH-1 on carry; sub clamps to 0 on borrow.
- Arithmetic, signed:
  - out_sum = exact WIDTH+1-bit two's-complement result (sign-extend A and B).
  - out_sat clamps to 2^(WIDTH-1)-1 / -2^(WIDTH-1).
- out_ovf = 1 exactly when clamping occurred.
- Saturation and overflow are computed combinationally from the last-stage registers; no extra latency.
- Reset mid-operation: in-flight ops are discarded; no stale result is ever presented after rst deasserts.
- STAGES=1 degenerates to a single-register adder with latency 1.

Decomposition:
- adder_pkg:
  - typedef enum {OP_ADD, OP_SUB} add_op_e
  - function seg_width(width, stages) returning ceil(width/stages)
  - localparam sat bounds helpers (max/min for signed/unsigned)
- Sub-module adder_segment (parameter SEG_W): combinational ripple of SEG_W bits with carry-in/carry-out, built from the existing full_adder cell. One instance per stage via generate.

Test Plan:
- WIDTH=8, STAGES=2, unsigned; 200+100, out_ready=1 -> after 2 cycles out_sum=9'h12C, out_sat=8'hFF, out_ovf=1, tag preserved.
- SIGNED=1; -128 - 1 (8'h80 sub 8'h01) -> out_sum=9'h17F (-129), out_sat=8'h80, out_ovf=1; 5-7 -> 9'h1FE, out_sat=8'hFE, ovf=0.
- STAGES=3 (segments 3,3,2); 8'hFF+8'h01 -> out_sum=9'h100 (carry crosses both stage boundaries), unsigned sat=8'hFF, ovf=1.
- 4 back-to-back ops, tags 0..3, out_ready=1 -> out_valid high 4 consecutive cycles starting cycle 2, tags 0,1,2,3 in order.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready falls after 2 ops buffered, held output stable; on release, all ops emerge once each, in order.
- Assert rst with 2 ops in flight -> out_valid=0 and in_ready=0 immediately (same cycle, async); after release in_ready=1 next cycle, no result appears until a new op is accepted.
